// File: rtl/sram_arbiter.sv
// Two-port arbiter and cycle sequencer for a 16-bit asynchronous SRAM with registered strobes.
// Optional macro SRAM_ARB_ROUND_ROBIN_EN: round-robin instead of fixed m0 priority.
module sram_arbiter #(
  parameter int ADDR_WIDTH  = 19,
  parameter int DATA_WIDTH  = 16,
  parameter int WAIT_STATES = 0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  m0_req,
  input  logic                  m0_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [1:0]            m0_be,
  output logic                  m0_gnt,
  output logic                  m0_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  input  logic                  m1_req,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  input  logic [1:0]            m1_be,
  output logic                  m1_gnt,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  sram_ce,
  output logic                  sram_we,
  output logic                  sram_oe,
  output logic                  sram_lb,
  output logic                  sram_ub,
  output logic [ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0] sram_dout,
  output logic                  sram_drive,
  input  logic [DATA_WIDTH-1:0] sram_din
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_W_SETUP  = 3'd1;
  localparam logic [2:0] S_W_STROBE = 3'd2;
  localparam logic [2:0] S_W_HOLD   = 3'd3;
  localparam logic [2:0] S_R_ADDR   = 3'd4;
  localparam logic [2:0] S_R_SAMPLE = 3'd5;
  localparam logic [2:0] WS_INIT    = 3'(WAIT_STATES);

  logic [2:0]            state_q, state_d;
  logic [2:0]            wait_q, wait_d;
  logic                  owner_q, owner_d;
  logic [1:0]            be_q, be_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ce_q, ce_d, we_q, we_d, oe_q, oe_d;
  logic                  lb_q, lb_d, ub_q, ub_d, drive_q, drive_d;
  logic                  m0_gnt_q, m0_gnt_d, m1_gnt_q, m1_gnt_d;
  logic                  m0_rvalid_q, m0_rvalid_d, m1_rvalid_q, m1_rvalid_d;
  logic [DATA_WIDTH-1:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic                  pick_m1_s;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
  logic last_m1_q, last_m1_d;

  // Contended grants go to the port that was not granted last.
  always_comb begin
    if (m0_req && m1_req) begin
      pick_m1_s = ~last_m1_q;
    end else begin
      pick_m1_s = m1_req;
    end
    if (state_q == S_IDLE && (m0_req || m1_req)) begin
      last_m1_d = pick_m1_s;
    end else begin
      last_m1_d = last_m1_q;
    end
  end

  // Pointer starts as if m1 was granted last, so m0 wins first.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      last_m1_q <= 1'b1;
    end else begin
      last_m1_q <= last_m1_d;
    end
  end
`else
  // Fixed priority: m1 only wins when m0 is idle.
  always_comb begin
    pick_m1_s = m1_req & ~m0_req;
  end
`endif

  // Next-state, transaction latching and read-data capture.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    owner_d     = owner_q;
    be_d        = be_q;
    addr_d      = addr_q;
    dout_d      = dout_q;
    m0_gnt_d    = 1'b0;
    m1_gnt_d    = 1'b0;
    m0_rvalid_d = 1'b0;
    m1_rvalid_d = 1'b0;
    m0_rdata_d  = m0_rdata_q;
    m1_rdata_d  = m1_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (m0_req || m1_req) begin
          owner_d  = pick_m1_s;
          be_d     = pick_m1_s ? m1_be   : m0_be;
          addr_d   = pick_m1_s ? m1_addr : m0_addr;
          wait_d   = WS_INIT;
          m0_gnt_d = ~pick_m1_s;
          m1_gnt_d = pick_m1_s;
          if (pick_m1_s ? m1_we : m0_we) begin
            dout_d  = pick_m1_s ? m1_wdata : m0_wdata;
            state_d = S_W_SETUP;
          end else begin
            state_d = S_R_ADDR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_W_SETUP: state_d = S_W_STROBE;
      S_W_STROBE: begin
        if (wait_q == 3'd0) begin
          state_d = S_W_HOLD;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_W_HOLD: state_d = S_IDLE;
      S_R_ADDR: begin
        if (wait_q == 3'd0) begin
          state_d = S_R_SAMPLE;
        end else begin
          wait_d = wait_q - 3'd1;
        end
      end
      S_R_SAMPLE: begin
        state_d = S_IDLE;
        if (owner_q) begin
          m1_rvalid_d = 1'b1;
          m1_rdata_d  = sram_din;
        end else begin
          m0_rvalid_d = 1'b1;
          m0_rdata_d  = sram_din;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so the pins come straight from flops.
  always_comb begin
    ce_d    = 1'b1;
    we_d    = 1'b1;
    oe_d    = 1'b1;
    lb_d    = 1'b1;
    ub_d    = 1'b1;
    drive_d = 1'b0;
    case (state_d)
      S_W_SETUP, S_W_STROBE: begin
        ce_d    = 1'b0;
        we_d    = (state_d == S_W_STROBE) ? 1'b0 : 1'b1;
        lb_d    = ~be_d[0];
        ub_d    = ~be_d[1];
        drive_d = 1'b1;
      end
      S_W_HOLD: drive_d = 1'b1;
      S_R_ADDR, S_R_SAMPLE: begin
        ce_d = 1'b0;
        oe_d = 1'b0;
        lb_d = ~be_d[0];
        ub_d = ~be_d[1];
      end
      default: drive_d = 1'b0;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      wait_q      <= 3'd0;
      owner_q     <= 1'b0;
      be_q        <= 2'b00;
      addr_q      <= '0;
      dout_q      <= '0;
      ce_q        <= 1'b1;
      we_q        <= 1'b1;
      oe_q        <= 1'b1;
      lb_q        <= 1'b1;
      ub_q        <= 1'b1;
      drive_q     <= 1'b0;
      m0_gnt_q    <= 1'b0;
      m1_gnt_q    <= 1'b0;
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      wait_q      <= wait_d;
      owner_q     <= owner_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      dout_q      <= dout_d;
      ce_q        <= ce_d;
      we_q        <= we_d;
      oe_q        <= oe_d;
      lb_q        <= lb_d;
      ub_q        <= ub_d;
      drive_q     <= drive_d;
      m0_gnt_q    <= m0_gnt_d;
      m1_gnt_q    <= m1_gnt_d;
      m0_rvalid_q <= m0_rvalid_d;
      m1_rvalid_q <= m1_rvalid_d;
      m0_rdata_q  <= m0_rdata_d;
      m1_rdata_q  <= m1_rdata_d;
    end
  end

  assign sram_ce    = ce_q;
  assign sram_we    = we_q;
  assign sram_oe    = oe_q;
  assign sram_lb    = lb_q;
  assign sram_ub    = ub_q;
  assign sram_addr  = addr_q;
  assign sram_dout  = dout_q;
  assign sram_drive = drive_q;
  assign m0_gnt     = m0_gnt_q;
  assign m1_gnt     = m1_gnt_q;
  assign m0_rvalid  = m0_rvalid_q;
  assign m1_rvalid  = m1_rvalid_q;
  assign m0_rdata   = m0_rdata_q;
  assign m1_rdata   = m1_rdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM model, read-data scoreboard, per-cycle strobe checks.
module tb_sram_arbiter;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [18:0] m0_addr = 19'd0, m1_addr = 19'd0;
  logic [15:0] m0_wdata = 16'd0, m1_wdata = 16'd0;
  logic [1:0] m0_be = 2'b00, m1_be = 2'b00;
  logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid;
  logic [15:0] m0_rdata, m1_rdata;
  logic sram_ce, sram_we, sram_oe, sram_lb, sram_ub, sram_drive;
  logic [18:0] sram_addr;
  logic [15:0] sram_dout, sram_din;

  logic d2_req = 1'b0, d2_we = 1'b0;
  logic [18:0] d2_addr = 19'd0;
  logic [15:0] d2_wdata = 16'd0;
  logic [1:0] d2_be = 2'b00;
  logic d2_gnt, d2_rvalid, d2_m1_gnt, d2_m1_rvalid;
  logic [15:0] d2_rdata, d2_m1_rdata, d2_dout;
  logic d2_ce, d2_swe, d2_oe, d2_lb, d2_ub, d2_drive;
  logic [18:0] d2_saddr;

  sram_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(16), .WAIT_STATES(0)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .sram_ce(sram_ce), .sram_we(sram_we), .sram_oe(sram_oe), .sram_lb(sram_lb), .sram_ub(sram_ub),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_drive(sram_drive), .sram_din(sram_din));

  sram_arbiter #(.ADDR_WIDTH(19), .DATA_WIDTH(16), .WAIT_STATES(2)) dut2 (
    .clk(clk), .resetn(resetn),
    .m0_req(d2_req), .m0_we(d2_we), .m0_addr(d2_addr), .m0_wdata(d2_wdata), .m0_be(d2_be),
    .m0_gnt(d2_gnt), .m0_rvalid(d2_rvalid), .m0_rdata(d2_rdata),
    .m1_req(1'b0), .m1_we(1'b0), .m1_addr(19'd0), .m1_wdata(16'd0), .m1_be(2'b00),
    .m1_gnt(d2_m1_gnt), .m1_rvalid(d2_m1_rvalid), .m1_rdata(d2_m1_rdata),
    .sram_ce(d2_ce), .sram_we(d2_swe), .sram_oe(d2_oe), .sram_lb(d2_lb), .sram_ub(d2_ub),
    .sram_addr(d2_saddr), .sram_dout(d2_dout), .sram_drive(d2_drive), .sram_din(16'h0000));

  // SRAM model: byte-masked writes while CE and WE are low, reads while CE and OE are low.
  logic [15:0] mem [0:255];
  always @(posedge clk) begin
    if (!sram_ce && !sram_we) begin
      if (!sram_lb) mem[sram_addr[7:0]][7:0] <= sram_dout[7:0];
      if (!sram_ub) mem[sram_addr[7:0]][15:8] <= sram_dout[15:8];
    end
  end
  assign sram_din = (!sram_ce && !sram_oe) ? mem[sram_addr[7:0]] : 16'h0000;

  int total = 0;
  int bad = 0;
  logic [15:0] ref_mem [0:255];
  logic [15:0] exp_q0 [$];
  logic [15:0] exp_q1 [$];
  logic [5:0]  cap_ctl  [0:7];  // {gnt, ce, we, oe, drive, rvalid}
  logic [1:0]  cap_bl   [0:7];  // {ub, lb}
  logic [18:0] cap_addr [0:7];
  logic [15:0] cap_dout [0:7];

  // Read-data scoreboard: every rvalid pops the value expected when the read was issued.
  always @(negedge clk) begin : mon
    logic [15:0] e;
    if (m0_rvalid) begin
      total++;
      if (exp_q0.size() == 0) begin
        bad++; $display("FAIL m0_rvalid_unexpected got=%h", m0_rdata);
      end else begin
        e = exp_q0.pop_front();
        if (m0_rdata !== e) begin bad++; $display("FAIL m0_rdata got=%h exp=%h", m0_rdata, e); end
      end
    end
    if (m1_rvalid) begin
      total++;
      if (exp_q1.size() == 0) begin
        bad++; $display("FAIL m1_rvalid_unexpected got=%h", m1_rdata);
      end else begin
        e = exp_q1.pop_front();
        if (m1_rdata !== e) begin bad++; $display("FAIL m1_rdata got=%h exp=%h", m1_rdata, e); end
      end
    end
  end

  task automatic do_txn(input bit port, input bit we, input logic [18:0] addr,
                        input logic [15:0] wd, input logic [1:0] be);
    @(posedge clk); #1;
    if (port) begin m1_req = 1'b1; m1_we = we; m1_addr = addr; m1_wdata = wd; m1_be = be; end
    else begin m0_req = 1'b1; m0_we = we; m0_addr = addr; m0_wdata = wd; m0_be = be; end
    if (we) begin
      if (be[0]) ref_mem[addr[7:0]][7:0] = wd[7:0];
      if (be[1]) ref_mem[addr[7:0]][15:8] = wd[15:8];
    end else if (port) exp_q1.push_back(ref_mem[addr[7:0]]);
    else exp_q0.push_back(ref_mem[addr[7:0]]);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      cap_ctl[c]  = {port ? m1_gnt : m0_gnt, sram_ce, sram_we, sram_oe, sram_drive,
                     port ? m1_rvalid : m0_rvalid};
      cap_bl[c]   = {sram_ub, sram_lb};
      cap_addr[c] = sram_addr;
      cap_dout[c] = sram_dout;
      if (cap_ctl[c][5]) begin
        if (port) m1_req = 1'b0; else m0_req = 1'b0;
      end
    end
    m0_req = 1'b0;
    m1_req = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({sram_ce, sram_we, sram_oe, sram_lb, sram_ub, sram_drive} !== 6'b111110 ||
        sram_addr !== 19'd0 || sram_dout !== 16'd0) begin
      bad++; $display("FAIL reset_pins got=%b addr=%h dout=%h exp=111110/0/0",
        {sram_ce, sram_we, sram_oe, sram_lb, sram_ub, sram_drive}, sram_addr, sram_dout);
    end
    total++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid} !== 4'b0000 || m0_rdata !== 16'd0 || m1_rdata !== 16'd0) begin
      bad++; $display("FAIL reset_ports got=%b rd0=%h rd1=%h exp=0000/0/0",
        {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid}, m0_rdata, m1_rdata);
    end
    resetn = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    logic [5:0] ew [0:4];
    ew = '{6'b011100, 6'b101110, 6'b000110, 6'b011110, 6'b011100};
    do_txn(1'b0, 1'b1, 19'h00012, 16'hA5C3, 2'b11);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (cap_ctl[c] !== ew[c]) begin
        bad++; $display("FAIL write_ctl cyc=%0d got=%b exp=%b", c, cap_ctl[c], ew[c]);
      end
    end
    total++;
    if (cap_bl[2] !== 2'b00 || cap_addr[2] !== 19'h00012 || cap_dout[2] !== 16'hA5C3) begin
      bad++; $display("FAIL write_bus got=%b/%h/%h exp=00/00012/a5c3", cap_bl[2], cap_addr[2], cap_dout[2]);
    end
  endtask

  task automatic test_read();
    logic [5:0] er [0:4];
    er = '{6'b011100, 6'b101000, 6'b001000, 6'b011101, 6'b011100};
    do_txn(1'b1, 1'b0, 19'h00012, 16'h0000, 2'b11);
    for (int c = 0; c < 5; c++) begin
      total++;
      if (cap_ctl[c] !== er[c]) begin
        bad++; $display("FAIL read_ctl cyc=%0d got=%b exp=%b", c, cap_ctl[c], er[c]);
      end
    end
    total++;
    if (m1_rdata !== 16'hA5C3 || m0_rdata !== 16'h12CD) begin
      bad++; $display("FAIL read_hold got=%h/%h exp=a5c3/12cd", m1_rdata, m0_rdata);
    end
  endtask

  task automatic test_partial_and_upper_addr();
    do_txn(1'b1, 1'b1, 19'h7FF34, 16'h1234, 2'b11);
    do_txn(1'b0, 1'b1, 19'h7FF34, 16'hABCD, 2'b01);
    total++;
    if (cap_bl[2] !== 2'b10 || cap_ctl[2] !== 6'b000110) begin
      bad++; $display("FAIL partial_write got=%b/%b exp=10/000110", cap_bl[2], cap_ctl[2]);
    end
    do_txn(1'b0, 1'b0, 19'h7FF34, 16'h0000, 2'b11);
    total++;
    if (cap_addr[1] !== 19'h7FF34) begin
      bad++; $display("FAIL upper_addr got=%h exp=7ff34", cap_addr[1]);
    end
  endtask

  task automatic test_arbitration();
    int order [$];
    bit exp1;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 19'h00040; m0_wdata = 16'h1111; m0_be = 2'b11;
    m1_req = 1'b1; m1_we = 1'b1; m1_addr = 19'h00041; m1_wdata = 16'h2222; m1_be = 2'b11;
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      @(negedge clk);
      if (m0_gnt && m1_gnt) begin total++; bad++; $display("FAIL arb_double_gnt cyc=%0d", c); end
      if (m0_gnt) order.push_back(0);
      if (m1_gnt) order.push_back(1);
    end
    m0_req = 1'b0; m1_req = 1'b0;
    total++;
    if (order.size() != 4) begin
      bad++; $display("FAIL arb_timeout grants=%0d exp=4", order.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
`ifdef SRAM_ARB_ROUND_ROBIN_EN
        exp1 = (i % 2) == 1;
`else
        exp1 = 1'b0;
`endif
        total++;
        if (order[i] != int'(exp1)) begin
          bad++; $display("FAIL arb_order idx=%0d got=m%0d exp=m%0d", i, order[i], exp1);
        end
      end
    end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_be_zero();
    do_txn(1'b0, 1'b0, 19'h00012, 16'h0000, 2'b00);
    total++;
    if (cap_bl[1] !== 2'b11 || cap_bl[2] !== 2'b11 || cap_ctl[1] !== 6'b101000 || cap_ctl[3] !== 6'b011101) begin
      bad++; $display("FAIL be_zero got=%b %b %b %b exp=11 11 101000 011101",
        cap_bl[1], cap_bl[2], cap_ctl[1], cap_ctl[3]);
    end
  endtask

  task automatic test_reset_mid();
    logic [5:0] ctl;
    int first;
    @(posedge clk); #1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = 19'h00080; m0_wdata = 16'h5555; m0_be = 2'b11;
    @(negedge clk);
    @(negedge clk);
    total++;
    if (m0_gnt !== 1'b1) begin bad++; $display("FAIL rstmid_gnt got=%b exp=1", m0_gnt); end
    m0_req = 1'b0;
    @(negedge clk);
    total++;
    if (sram_we !== 1'b0) begin bad++; $display("FAIL rstmid_strobe got=%b exp=0", sram_we); end
    resetn = 1'b0;
    @(negedge clk);
    total++;
    if ({sram_we, sram_ce, sram_drive} !== 3'b110) begin
      bad++; $display("FAIL rstmid_pins got=%b exp=110", {sram_we, sram_ce, sram_drive});
    end
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      ctl = {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, sram_we, sram_ce};
      total++;
      if (ctl !== 6'b000011) begin bad++; $display("FAIL rstmid_quiet cyc=%0d got=%b exp=000011", c, ctl); end
    end
    @(posedge clk); #1;
    m0_req = 1'b1; m0_addr = 19'h00081; m1_req = 1'b1; m1_we = 1'b1; m1_addr = 19'h00082; m1_be = 2'b11;
    first = -1;
    for (int c = 0; c < 20 && first < 0; c++) begin
      @(negedge clk);
      if (m0_gnt) first = 0;
      else if (m1_gnt) first = 1;
    end
    m0_req = 1'b0; m1_req = 1'b0;
    total++;
    if (first != 0) begin bad++; $display("FAIL rstmid_first got=%0d exp=0", first); end
    repeat (8) @(negedge clk);
  endtask

  task automatic test_wait_states();
    int lows;
    int first_low;
    int gnt_cyc;
    logic [1:0] bl;
    lows = 0; first_low = -1; gnt_cyc = -1; bl = 2'b11;
    @(posedge clk); #1;
    d2_req = 1'b1; d2_we = 1'b1; d2_addr = 19'h00022; d2_wdata = 16'hBEEF; d2_be = 2'b10;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (d2_gnt) begin gnt_cyc = c; d2_req = 1'b0; end
      if (!d2_swe) begin
        lows++;
        if (first_low < 0) begin first_low = c; bl = {d2_ub, d2_lb}; end
      end
    end
    d2_req = 1'b0;
    total++;
    if (lows != 3 || first_low != 2 || gnt_cyc != 1) begin
      bad++; $display("FAIL ws2_we got lows=%0d first=%0d gnt=%0d exp=3/2/1", lows, first_low, gnt_cyc);
    end
    total++;
    if (bl !== 2'b01) begin bad++; $display("FAIL ws2_bytes got=%b exp=01", bl); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_partial_and_upper_addr();
    test_read();
    test_arbitration();
    test_be_zero();
    test_reset_mid();
    test_wait_states();
    total++;
    if (exp_q0.size() != 0 || exp_q1.size() != 0) begin
      bad++; $display("FAIL missing_rvalid q0=%0d q1=%0d exp=0/0", exp_q0.size(), exp_q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single 16-bit asynchronous SRAM (active-low CE/WE/OE/LB/UB, 19-bit address) between two requesters, e.g. the memory test sequencer and the FT600 host datapath.
- Arbitrates between requesters, then sequences one complete SRAM read or write cycle from registered strobes.
- Drives the bidirectional data pads through a separate pad output-enable.
- Sits between the requesters and the SB_IO data pads / SRAM address pins in the top level.

Parameters:
- ADDR_WIDTH, 19, SRAM word address width.
- DATA_WIDTH, 16, SRAM data width. lb covers bits [7:0], ub covers bits [15:8].
- WAIT_STATES, 0, extra cycles added to the WE-low strobe and to the read address phase. Range 0..7.

Ports:
- clk  input  1  system clock (16 MHz PLL output)
- resetn  input  1  synchronous active-low reset
- m0_req  input  1  requester 0 transaction request; held until m0_gnt
- m0_we  input  1  1 = write, 0 = read
- m0_addr  input  ADDR_WIDTH  word address
- m0_wdata  input  DATA_WIDTH  write data
- m0_be  input  2  byte enables, active high, [1]=upper byte
- m0_gnt  output  1  one-cycle pulse: request accepted
- m0_rvalid  output  1  one-cycle pulse: m0_rdata valid
- m0_rdata  output  DATA_WIDTH  read data
- m1_*  same set as m0_*, for requester 1
- sram_ce, sram_we, sram_oe, sram_lb, sram_ub  output  1 each  SRAM strobes, active low, registered
- sram_addr  output  ADDR_WIDTH  SRAM address, registered
- sram_dout  output  DATA_WIDTH  data to pads, registered
- sram_drive  output  1  pad output enable, 1 = FPGA drives data bus
- sram_din  input  DATA_WIDTH  data from pads

Behaviour:
- Reset (resetn=0 at a clk edge):
  - Next cycle: state IDLE; sram_ce, we, oe, lb, ub = 1; sram_drive=0; sram_addr=0; sram_dout=0.
  - All gnt and rvalid = 0; rdata = 0.
  - Round-robin pointer set so that m0 wins first.
  - Reset mid-transaction abandons it: no gnt or rvalid for it, and WE returns high on the next edge.
- States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_ADDR, R_SAMPLE. All outputs are registered and below are listed per state; unlisted strobes are 1.
  - IDLE: ce=1, drive=0.
  - W_SETUP: ce=0; lb/ub = ~be; addr and dout loaded; drive=1; 1 cycle.
  - W_STROBE: as W_SETUP plus we=0; lasts 1+WAIT_STATES cycles.
  - W_HOLD: we=1; addr, dout and drive held; 1 cycle; then IDLE.
  - R_ADDR: ce=0, oe=0, lb/ub = ~be, drive=0; lasts 1+WAIT_STATES cycles.
  - R_SAMPLE: as R_ADDR; sram_din captured into the winner's rdata at the end of this cycle; then IDLE.
- Arbitration:
  - Sampled only in IDLE. The winner's addr, wdata, be and we are latched at that edge.
  - The winner's gnt pulses in the first cycle of W_SETUP or R_ADDR.
  - Requests arriving while not in IDLE wait; req must stay high until gnt.
  - A requester may present its next request the cycle after gnt. The bus has one idle cycle between transactions.
- Latency (WAIT_STATES=0, req sampled in IDLE at cycle 0):
  - Write: gnt at cycle 1; we low at cycle 2; IDLE at cycle 4.
  - Read: gnt at cycle 1; rvalid and rdata at cycle 3, which is also the IDLE cycle.
  - Each WAIT_STATE adds one cycle.
- rdata holds its value until the next read completion for that port. The other port's rdata is unaffected.
- be=00: the full cycle still runs with lb=ub=1. gnt is issued, and rvalid for a read returns the captured bus value.
- The address is used as given; there is no wrap or range check. Upper address bits are passed through unchanged.
- sram_drive never overlaps sram_oe=0: the IDLE gap guarantees at least one cycle between drive=0 and oe=0 in either order.

Optional Feature:
- Macro SRAM_ARB_ROUND_ROBIN_EN.
- Defined: when both ports request together, the port not granted last wins. A pointer updates on every grant.
- Undefined: m0 always wins when both request; m1 can starve.

Test Plan:
- m0 write addr=0x00012, wdata=0xA5C3, be=11, WS=0 → gnt at cycle 1; sram_ce=0, we=0 only at cycle 2; lb=ub=0; drive=1 cycles 1-3; IDLE at cycle 4.
- m1 read of addr 0x00012 with model SRAM returning 0xA5C3 → m1_rvalid one cycle at cycle 3 with m1_rdata=0xA5C3; oe=0 cycles 1-2; drive=0 throughout.
- m0 and m1 requesting continuously → with SRAM_ARB_ROUND_ROBIN_EN, grants alternate m0,m1,m0,m1. Without the macro, only m0 is granted.
- WAIT_STATES=2 write with be=10 → we low for exactly 3 cycles; ub=0, lb=1.
- resetn low during W_STROBE → next cycle we=1, ce=1, drive=0; no further gnt or rvalid; after release, m0 is granted first.
- m0 read with be=00 → full cycle with lb=ub=1; rvalid still pulses at cycle 3.
